// File: rtl/bkm_data_iter.sv
// Iterative BKM datapath: N-step E-mode (complex multiply by 1 + d*2^-n) or L-mode (log-term subtract).
// Build option: define BKM_ITER_SAT_EN to clamp overflowing results; otherwise they wrap.
module bkm_data_iter #(
  parameter int W     = 8,
  parameter int N     = 8,
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             ena,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [W-1:0]     x0,
  input  logic [W-1:0]     y0,
  output logic             busy,
  output logic             done,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic [1:0]       d_x,
  input  logic [1:0]       d_y,
  output logic [LOG2N-1:0] lut_n,
  output logic [1:0]       lut_dx,
  output logic [1:0]       lut_dy,
  input  logic [W-1:0]     lut_X,
  input  logic [W-1:0]     lut_Y,
  output logic [W-1:0]     x_out,
  output logic [W-1:0]     y_out,
  output logic             err_digit,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  state_t             state_q, state_d;
  logic [LOG2N-1:0]   n_q;
  logic               mode_q;
  logic               load, step;

  logic               dx_p, dx_m, dy_p, dy_m, dig_ill;
  logic signed [W-1:0]   xs, ys;
  logic signed [W+1:0]   xe, ye, xse, yse, lxe, lye;
  logic signed [W+1:0]   x_sum, y_sum;
  logic               x_ovf, y_ovf;
  logic [W-1:0]       x_wb, y_wb;

  assign busy    = (state_q == S_RUN) || (state_q == S_DONE);
  assign done    = (state_q == S_DONE);
  assign d_ready = (state_q == S_RUN) && ena;
  assign lut_n   = n_q;
  assign lut_dx  = d_x;
  assign lut_dy  = d_y;

  // Digit decode: the illegal code 10 contributes nothing but is flagged.
  assign dx_p    = (d_x == 2'b01);
  assign dx_m    = (d_x == 2'b11);
  assign dy_p    = (d_y == 2'b01);
  assign dy_m    = (d_y == 2'b11);
  assign dig_ill = (d_x == 2'b10) || (d_y == 2'b10);

  assign xs  = $signed(x_out) >>> n_q;
  assign ys  = $signed(y_out) >>> n_q;
  assign xe  = {{2{x_out[W-1]}}, x_out};
  assign ye  = {{2{y_out[W-1]}}, y_out};
  assign xse = {{2{xs[W-1]}}, xs};
  assign yse = {{2{ys[W-1]}}, ys};
  assign lxe = {{2{lut_X[W-1]}}, lut_X};
  assign lye = {{2{lut_Y[W-1]}}, lut_Y};

  always_comb begin
    x_sum = xe;
    y_sum = ye;
    if (mode_q) begin
      x_sum = xe - lxe;
      y_sum = ye - lye;
    end else begin
      if (dx_p) begin
        x_sum = x_sum + xse;
        y_sum = y_sum + yse;
      end
      if (dx_m) begin
        x_sum = x_sum - xse;
        y_sum = y_sum - yse;
      end
      if (dy_p) begin
        x_sum = x_sum - yse;
        y_sum = y_sum + xse;
      end
      if (dy_m) begin
        x_sum = x_sum + yse;
        y_sum = y_sum - xse;
      end
    end
  end

  // In range iff the top three bits of the W+2-bit sum agree.
  assign x_ovf = !((&x_sum[W+1:W-1]) || !(|x_sum[W+1:W-1]));
  assign y_ovf = !((&y_sum[W+1:W-1]) || !(|y_sum[W+1:W-1]));

`ifdef BKM_ITER_SAT_EN
  assign x_wb = !x_ovf ? x_sum[W-1:0] :
                x_sum[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  assign y_wb = !y_ovf ? y_sum[W-1:0] :
                y_sum[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
  assign x_wb = x_sum[W-1:0];
  assign y_wb = y_sum[W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (d_valid) begin
          step = 1'b1;
          if (n_q == LAST) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      mode_q    <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      err_digit <= 1'b0;
      ovf       <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      if (load) begin
        x_out     <= x0;
        y_out     <= y0;
        mode_q    <= mode;
        n_q       <= '0;
        err_digit <= 1'b0;
        ovf       <= 1'b0;
      end else if (step) begin
        x_out <= x_wb;
        y_out <= y_wb;
        n_q   <= n_q + 1'b1;
        if (dig_ill) err_digit <= 1'b1;
        if (x_ovf || y_ovf) ovf <= 1'b1;
      end
    end
  end

endmodule
